// File: rtl/jtframe_credits_pkg.sv
// Shared definitions for the credits overlay: sequencer state encoding,
// page geometry and the vpos width derivation also used by the renderer.
package jtframe_credits_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SCROLL = 2'd2,
    ST_REWIND = 2'd3
  } credits_state_e;

  localparam int unsigned PAGE_LINES = 256;

  function automatic int unsigned credits_vposw(input int unsigned pages);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << w) < pages * PAGE_LINES) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/jtframe_credits_edge.sv
// Registered rising-edge detector; the history register only advances on cen_i,
// so the pulse is qualified by the same enable.
module jtframe_credits_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic cen_i,
  input  logic d_i,
  output logic rise_o
);

  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= 1'b0;
    else if (cen_i) last_q <= d_i;
  end

  assign rise_o = cen_i & d_i & ~last_q;

endmodule

// File: rtl/jtframe_credits_seq.sv
// Frame-level credits sequencer: hold / scroll / rewind of the overlay pages.
// Optional JTFRAME_CREDITS_AUTOHIDE_EN: hide and stop after two full loops.
module jtframe_credits_seq
  import jtframe_credits_pkg::*;
#(
  parameter int PAGES    = 2,
  parameter int VPOSW    = int'(credits_vposw(PAGES)),
  parameter int SPEED    = 2,
  parameter int FASTSTEP = 8,
  parameter int HOLD     = 120,
  parameter int BLKPOL   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen,
  input  logic             VB,
  input  logic             enable,
  input  logic             toggle,
  input  logic             skip,
  output logic [VPOSW-1:0] vpos,
  output logic [3:0]       page,
  output logic             show,
  output logic             busy
);

  localparam int HW = (HOLD  > 0) ? $clog2(HOLD + 1)  : 1;
  localparam int SW = (SPEED > 0) ? $clog2(SPEED + 1) : 1;

  credits_state_e   state_q, state_d;
  logic [VPOSW-1:0] vpos_q, vpos_d;
  logic             show_q, show_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [SW-1:0]    spd_q, spd_d;
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
  logic [1:0]       loop_q, loop_d;
`endif

  logic             vb, tick, en_rise, tg_rise, sk_rise;
  logic             hold_done, spd_done, last_page;
  logic [4:0]       next_page;
  logic [VPOSW-1:0] vpos_inc, vpos_fast, skip_vpos;

  assign vb = (BLKPOL != 0) ? VB : ~VB;

  jtframe_credits_edge u_vb (.clk(clk), .rst_n(rst_n), .cen_i(pxl_cen), .d_i(vb),     .rise_o(tick));
  jtframe_credits_edge u_en (.clk(clk), .rst_n(rst_n), .cen_i(1'b1),    .d_i(enable), .rise_o(en_rise));
  jtframe_credits_edge u_tg (.clk(clk), .rst_n(rst_n), .cen_i(1'b1),    .d_i(toggle), .rise_o(tg_rise));
  jtframe_credits_edge u_sk (.clk(clk), .rst_n(rst_n), .cen_i(1'b1),    .d_i(skip),   .rise_o(sk_rise));

  assign page      = 4'(vpos_q >> 8);
  assign last_page = (int'(page) == PAGES - 1);
  assign next_page = {1'b0, page} + 5'd1;
  assign skip_vpos = (int'(next_page) == PAGES) ? '0 : VPOSW'({next_page, 8'd0});
  assign vpos_inc  = vpos_q + VPOSW'(1);
  assign vpos_fast = vpos_q + VPOSW'(FASTSTEP);
  // Counters compare their incremented value, so HOLD ticks of hold end the
  // page and SPEED of 0 or 1 both step every frame; neither can wrap.
  assign hold_done = (int'(hold_q) + 1) >= HOLD;
  assign spd_done  = (int'(spd_q)  + 1) >= SPEED;

  always_comb begin
    state_d = state_q;
    vpos_d  = vpos_q;
    show_d  = show_q;
    hold_d  = hold_q;
    spd_d   = spd_q;
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
    loop_d  = loop_q;
`endif
    if (!enable) begin
      state_d = ST_OFF;
      show_d  = 1'b0;
    end else if (en_rise) begin
      state_d = ST_HOLD;
      vpos_d  = '0;
      hold_d  = '0;
      spd_d   = '0;
      show_d  = 1'b1;
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
      loop_d  = '0;
`endif
    end else if (state_q != ST_OFF) begin
      if (tg_rise) show_d = ~show_q;
      if (sk_rise) begin
        state_d = ST_HOLD;
        vpos_d  = skip_vpos;
        hold_d  = '0;
        spd_d   = '0;
      end else if (tick) begin
        case (state_q)
          ST_HOLD: begin
            if (!hold_done) begin
              hold_d = hold_q + HW'(1);
            end else if (PAGES > 1) begin
              state_d = last_page ? ST_REWIND : ST_SCROLL;
              spd_d   = '0;
            end
          end
          ST_SCROLL: begin
            if (spd_done) begin
              spd_d  = '0;
              vpos_d = vpos_inc;
              if (vpos_inc[7:0] == 8'd0) begin
                state_d = ST_HOLD;
                hold_d  = '0;
              end
            end else begin
              spd_d = spd_q + SW'(1);
            end
          end
          ST_REWIND: begin
            vpos_d = vpos_fast;
            if (vpos_fast == '0) begin
              state_d = ST_HOLD;
              hold_d  = '0;
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
              loop_d  = loop_q + 2'd1;
              if (loop_q == 2'd1) begin
                state_d = ST_OFF;
                show_d  = 1'b0;
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      vpos_q  <= '0;
      show_q  <= 1'b0;
      hold_q  <= '0;
      spd_q   <= '0;
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
      loop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      vpos_q  <= vpos_d;
      show_q  <= show_d;
      hold_q  <= hold_d;
      spd_q   <= spd_d;
`ifdef JTFRAME_CREDITS_AUTOHIDE_EN
      loop_q  <= loop_d;
`endif
    end
  end

  assign vpos = vpos_q;
  assign show = show_q;
  assign busy = (state_q == ST_SCROLL) || (state_q == ST_REWIND);

endmodule
